osc_cmd_regbank: RTL
====================

# osc_cmd_regbank

Parametrised command decoder and register bank for N_OSC DDS oscillators, placed between the SPI command receiver and the oscillator/modulation datapath. Each command is an 8-bit opcode/field/channel word plus a data word. Tuning, waveform and pulse-width writes go to per-channel shadow registers and reach the oscillators only through a multi-cycle COMMIT walk, so a retune is glitch-free. Also handles enable masks, mode select, shadow readback and illegal-command flagging.

## Interface
- N_OSC, 4: oscillator channels, 1..8, ≤ DATAWORD_WIDTH
- DATAWORD_WIDTH, 16: data word width
- TUNING_WIDTH, 14; WAVE_SEL_WIDTH, 3; PULSEWIDTH_WIDTH, 12; MODE_SEL_WIDTH, 2: field widths, each ≤ DATAWORD_WIDTH
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- cmd_word  in  8  [7:5] opcode, [4:3] field, [2:0] channel
- data_word  in  DATAWORD_WIDTH  command payload
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
- osc_en  out  N_OSC  per-channel enable
- osc_tune  out  N_OSC*TUNING_WIDTH  active tuning words, channel c at [c*TUNING_WIDTH +: TUNING_WIDTH]
- osc_wave  out  N_OSC*WAVE_SEL_WIDTH  active waveform selects, same packing
- osc_pw  out  N_OSC*PULSEWIDTH_WIDTH  active pulse widths, same packing
- mode_sel  out  MODE_SEL_WIDTH  output modulation mode
- rd_data  out  DATAWORD_WIDTH  readback value
- rd_valid  out  1  one-cycle pulse, rd_data valid
- commit_done  out  1  one-cycle pulse at end of commit walk
- cmd_err  out  1  one-cycle pulse on an illegal command

## Operation
- Opcodes:
  - 000 NOP.
  - 001 WRITE: loads the field into shadow[channel]; field 0 tune, 1 wave, 2 pw, 3 mode. Mode has no shadow and writes mode_sel directly; the channel bits are ignored for mode.
  - 010 COMMIT: data_word[N_OSC-1:0] is the channel mask.
  - 011 ENABLE: osc_en <= data_word[N_OSC-1:0].
  - 100 READ: rd_data <= shadow field (mode field returns mode_sel), zero-extended.
  - 101–111: reserved.
- Field values are the low bits of data_word; upper bits are ignored.
- Error cases: a reserved opcode, or channel ≥ N_OSC on WRITE (fields 0–2) or READ, raises cmd_err and changes no state.
- FSM states: IDLE, EXEC, COMMIT.
  - IDLE: on accept, register cmd_word/data_word, go to EXEC.
  - EXEC: execute the registered command. Go to COMMIT with idx=0 for COMMIT, otherwise to IDLE.
  - COMMIT: each cycle, if mask[idx] copy shadow[idx] (tune, wave, pw together) into active[idx], then idx++. After idx = N_OSC-1, assert commit_done, go to IDLE.
- A COMMIT with mask 0 still walks all N_OSC cycles, copies nothing, and pulses commit_done.
- No command is accepted during EXEC or COMMIT; cmd_valid is ignored there.
- Reset at any time (including mid-walk) clears state to IDLE. Reset values:
  - all shadow and active registers, osc_en, mode_sel, rd_data, idx: 0
  - rd_valid, commit_done, cmd_err: 0
  - cmd_ready: 1 after reset deasserts.
  - Channels committed before the reset carry no partial state afterwards.

## Timing
- Accept at edge k; EXEC at edge k+1. Effects of WRITE, ENABLE, READ and errors are visible after edge k+1, with rd_valid/cmd_err high for the cycle k+1..k+2.
- cmd_ready returns high after edge k+1 for non-COMMIT commands: at most one command per 2 cycles.
- COMMIT: channel c updates at edge k+2+c. commit_done is high in the cycle after edge k+1+N_OSC. cmd_ready is high again in that same cycle.
- Active outputs change only in EXEC (ENABLE, mode) or COMMIT; shadow writes never alter osc_tune, osc_wave or osc_pw.

## Structure
- Shared package osc_cmd_pkg: opcode constants, field constants, state enum.
- Sub-module osc_chan_regs holds one channel's shadow and active registers and is instantiated N_OSC times via generate. Its ports: wr_en, wr_field, wr_data, commit, active outputs, and shadow readback.
- Top level holds the FSM, idx counter, decode, and readback mux.

## Test plan
- Reset, then WRITE tune ch1 = 0x1234 (TUNING_WIDTH 14) → shadow ch1 = 0x1234. osc_tune ch1 stays 0. READ ch1 tune → rd_valid with rd_data = 0x1234.
- WRITE tune ch0/ch2 = 0x0100/0x0200, then COMMIT mask 0b0101 → ch0 updates 2 cycles after accept, ch2 4 cycles after. ch1/ch3 unchanged. commit_done 5 cycles after accept (N_OSC=4).
- cmd_valid held high during a COMMIT walk → no acceptance until cmd_ready. The held command executes exactly once afterwards.
- ENABLE data 0x000A → osc_en = 4'b1010. WRITE mode 0x0003 → mode_sel = 2'b11 immediately after EXEC.
- Opcode 111, and WRITE to channel 5 with N_OSC=4 → cmd_err pulse each. Registers unchanged.
- sys_rst asserted mid-COMMIT (after ch0 copied) → all outputs 0 asynchronously, cmd_ready 1 after release, no commit_done.

Source files
------------

// File: rtl/osc_cmd_pkg.sv
// osc_cmd_pkg: opcode and field codes plus FSM states shared by the oscillator command decoder and its channel registers
package osc_cmd_pkg;
  localparam logic [2:0] OP_NOP = 3'd0, OP_WRITE = 3'd1, OP_COMMIT = 3'd2, OP_ENABLE = 3'd3, OP_READ = 3'd4;
  localparam logic [1:0] FLD_TUNE = 2'd0, FLD_WAVE = 2'd1, FLD_PW = 2'd2, FLD_MODE = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMMIT} state_t;
endpackage

// File: rtl/osc_chan_regs.sv
// osc_chan_regs: one channel's shadow/active tune, wave, pw; wr_en+wr_field+wr_data load a shadow field, commit copies all shadows to the active outputs, sh_* read the shadows back
module osc_chan_regs
  import osc_cmd_pkg::*;
#(
  parameter int DATAWORD_WIDTH = 16,
  parameter int TUNING_WIDTH = 14,
  parameter int WAVE_SEL_WIDTH = 3,
  parameter int PULSEWIDTH_WIDTH = 12
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_field,
  input  logic [DATAWORD_WIDTH-1:0]   wr_data,
  input  logic                        commit,
  output logic [TUNING_WIDTH-1:0]     tune,
  output logic [WAVE_SEL_WIDTH-1:0]   wave,
  output logic [PULSEWIDTH_WIDTH-1:0] pw,
  output logic [TUNING_WIDTH-1:0]     sh_tune,
  output logic [WAVE_SEL_WIDTH-1:0]   sh_wave,
  output logic [PULSEWIDTH_WIDTH-1:0] sh_pw
);
  logic unused_wr;
  assign unused_wr = ^wr_data;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_tune <= '0;
      sh_wave <= '0;
      sh_pw <= '0;
      tune <= '0;
      wave <= '0;
      pw <= '0;
    end else begin
      if (wr_en && wr_field == FLD_TUNE) sh_tune <= wr_data[TUNING_WIDTH-1:0];
      if (wr_en && wr_field == FLD_WAVE) sh_wave <= wr_data[WAVE_SEL_WIDTH-1:0];
      if (wr_en && wr_field == FLD_PW) sh_pw <= wr_data[PULSEWIDTH_WIDTH-1:0];
      if (commit) begin
        tune <= sh_tune;
        wave <= sh_wave;
        pw <= sh_pw;
      end
    end
  end
endmodule

// File: rtl/osc_cmd_regbank.sv
// osc_cmd_regbank: command decoder/register bank; cmd_word+data_word+cmd_valid/cmd_ready in, osc_en/osc_tune/osc_wave/osc_pw/mode_sel active outputs, rd_data/rd_valid readback, commit_done and cmd_err pulses
module osc_cmd_regbank
  import osc_cmd_pkg::*;
#(
  parameter int N_OSC = 4,
  parameter int DATAWORD_WIDTH = 16,
  parameter int TUNING_WIDTH = 14,
  parameter int WAVE_SEL_WIDTH = 3,
  parameter int PULSEWIDTH_WIDTH = 12,
  parameter int MODE_SEL_WIDTH = 2
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [7:0]                        cmd_word,
  input  logic [DATAWORD_WIDTH-1:0]         data_word,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  output logic [N_OSC-1:0]                  osc_en,
  output logic [N_OSC*TUNING_WIDTH-1:0]     osc_tune,
  output logic [N_OSC*WAVE_SEL_WIDTH-1:0]   osc_wave,
  output logic [N_OSC*PULSEWIDTH_WIDTH-1:0] osc_pw,
  output logic [MODE_SEL_WIDTH-1:0]         mode_sel,
  output logic [DATAWORD_WIDTH-1:0]         rd_data,
  output logic                              rd_valid,
  output logic                              commit_done,
  output logic                              cmd_err
);
  localparam int DW = DATAWORD_WIDTH;
  localparam int TW = TUNING_WIDTH;
  localparam int WW = WAVE_SEL_WIDTH;
  localparam int PW = PULSEWIDTH_WIDTH;
  state_t state;
  logic [7:0] cmd_q;
  logic [DW-1:0] data_q;
  logic [2:0] idx, op, ch;
  logic [1:0] fld;
  logic ch_ok, bad, wr_shadow;
  logic [DW-1:0] rd_mux;
  // sized for the full 3-bit channel field so any decoded channel indexes safely
  logic [TW-1:0] sh_tune [8];
  logic [WW-1:0] sh_wave [8];
  logic [PW-1:0] sh_pw [8];
  assign op = cmd_q[7:5];
  assign fld = cmd_q[4:3];
  assign ch = cmd_q[2:0];
  assign cmd_ready = state == S_IDLE;
  always_comb begin
    ch_ok = {1'b0, ch} < 4'(N_OSC);
    bad = op > OP_READ || (((op == OP_WRITE && fld != FLD_MODE) || op == OP_READ) && !ch_ok);
    wr_shadow = state == S_EXEC && !bad && op == OP_WRITE && fld != FLD_MODE;
    rd_mux = fld == FLD_TUNE ? DW'(sh_tune[ch]) :
             fld == FLD_WAVE ? DW'(sh_wave[ch]) :
             fld == FLD_PW   ? DW'(sh_pw[ch]) : DW'(mode_sel);
  end
  generate
    for (genvar c = 0; c < 8; c++) begin : g_ch
      if (c < N_OSC) begin : g_on
        osc_chan_regs #(
          .DATAWORD_WIDTH(DW), .TUNING_WIDTH(TW), .WAVE_SEL_WIDTH(WW), .PULSEWIDTH_WIDTH(PW)
        ) u_regs (
          .sys_clk(sys_clk),
          .sys_rst(sys_rst),
          .wr_en(wr_shadow && ch == 3'(c)),
          .wr_field(fld),
          .wr_data(data_q),
          .commit(state == S_COMMIT && idx == 3'(c) && data_q[c]),
          .tune(osc_tune[c*TW +: TW]),
          .wave(osc_wave[c*WW +: WW]),
          .pw(osc_pw[c*PW +: PW]),
          .sh_tune(sh_tune[c]),
          .sh_wave(sh_wave[c]),
          .sh_pw(sh_pw[c])
        );
      end else begin : g_off
        assign sh_tune[c] = '0;
        assign sh_wave[c] = '0;
        assign sh_pw[c] = '0;
      end
    end
  endgenerate
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
      cmd_q <= '0;
      data_q <= '0;
      idx <= '0;
      osc_en <= '0;
      mode_sel <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      commit_done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      commit_done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_q <= cmd_word;
          data_q <= data_word;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_IDLE;
          if (bad) cmd_err <= 1'b1;
          else if (op == OP_ENABLE) osc_en <= data_q[N_OSC-1:0];
          else if (op == OP_WRITE && fld == FLD_MODE) mode_sel <= data_q[MODE_SEL_WIDTH-1:0];
          else if (op == OP_READ) begin
            rd_data <= rd_mux;
            rd_valid <= 1'b1;
          end else if (op == OP_COMMIT) begin
            idx <= '0;
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          idx <= idx + 3'd1;
          if (idx == 3'(N_OSC - 1)) begin
            idx <= '0;
            commit_done <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
